// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;
  localparam logic [4:0] X0 = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> controller signal bundle: hazard sources in, stage enables/clears out.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       rs1_d, rs2_d, rd_e;
  logic             use_rs1_d, use_rs2_d;
  logic             mem_read_e, muldiv_e, redirect_e;
  logic             mem_req_m, mem_ready_m;
  logic             pc_we, fd_we, de_we, em_we, mw_we;
  logic             fd_clr, de_clr, em_clr, mw_clr;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_count, flush_count;

  modport master (
    output rs1_d, rs2_d, rd_e, use_rs1_d, use_rs2_d, mem_read_e, muldiv_e,
           redirect_e, mem_req_m, mem_ready_m,
    input  pc_we, fd_we, de_we, em_we, mw_we, fd_clr, de_clr, em_clr, mw_clr,
           muldiv_busy, stall_count, flush_count
  );
  modport slave (
    input  rs1_d, rs2_d, rd_e, use_rs1_d, use_rs2_d, mem_read_e, muldiv_e,
           redirect_e, mem_req_m, mem_ready_m,
    output pc_we, fd_we, de_we, em_we, mw_we, fd_clr, de_clr, em_clr, mw_clr,
           muldiv_busy, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_count <= '0;
    else if (i_inc && ~&r_count)      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: load-use, redirect, mul/div occupancy
// and data-memory wait, producing per-stage capture enables and bubble clears.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             reset,
  pipeline_ctrl_if.slave  bus
);
  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MULDIV_LAT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic w_mem_wait, w_load_use, w_md_stall, w_release, w_flush;
  logic w_pc_we, w_fd_we, w_de_we, w_em_we, w_mw_we;
  logic w_fd_clr, w_de_clr, w_em_clr, w_mw_clr;

  assign w_mem_wait = bus.mem_req_m & ~bus.mem_ready_m;
  assign w_load_use = bus.mem_read_e & (bus.rd_e != X0) &
                      ((bus.use_rs1_d & (bus.rs1_d == bus.rd_e)) |
                       (bus.use_rs2_d & (bus.rs2_d == bus.rd_e)));
  assign w_md_stall = ((r_state == RUN) & bus.muldiv_e) |
                      ((r_state == MULDIV) & (r_cnt < LAST));
  assign w_release  = (r_state == MULDIV) & (r_cnt == LAST);

  always_comb begin
    {w_pc_we, w_fd_we, w_de_we, w_em_we, w_mw_we} = 5'b11111;
    {w_fd_clr, w_de_clr, w_em_clr, w_mw_clr}      = 4'b0000;
    w_flush = 1'b0;
    if (w_mem_wait) begin
      {w_pc_we, w_fd_we, w_de_we, w_em_we} = 4'b0000;
      w_mw_clr = 1'b1;
    end else if (w_md_stall) begin
      {w_pc_we, w_fd_we, w_de_we} = 3'b000;
      w_em_clr = 1'b1;
    end else if (w_release) begin
      w_flush = 1'b0;
    end else if (bus.redirect_e) begin
      w_fd_clr = 1'b1;
      w_de_clr = 1'b1;
      w_flush  = 1'b1;
    end else if (w_load_use) begin
      {w_pc_we, w_fd_we} = 2'b00;
      w_de_clr = 1'b1;
    end
    // Reset forces every control low regardless of the inputs.
    if (reset) begin
      {w_pc_we, w_fd_we, w_de_we, w_em_we, w_mw_we} = 5'b00000;
      {w_fd_clr, w_de_clr, w_em_clr, w_mw_clr}      = 4'b0000;
      w_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else if (!w_mem_wait) begin
      case (r_state)
        RUN: if (bus.muldiv_e) begin
          r_state <= MULDIV;
          r_cnt   <= CW'(1);
        end
        MULDIV: if (r_cnt < LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.pc_we  = w_pc_we;
  assign bus.fd_we  = w_fd_we;
  assign bus.de_we  = w_de_we;
  assign bus.em_we  = w_em_we;
  assign bus.mw_we  = w_mw_we;
  assign bus.fd_clr = w_fd_clr & w_fd_we;
  assign bus.de_clr = w_de_clr & w_de_we;
  assign bus.em_clr = w_em_clr & w_em_we;
  assign bus.mw_clr = w_mw_clr & w_mw_we;
  assign bus.muldiv_busy = (r_state == MULDIV);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .i_inc(~w_pc_we), .o_count(bus.stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .i_inc(w_flush), .o_count(bus.flush_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MULDIV_LAT=4, CNT_W=4 so saturation is reachable).
module tb_pipeline_ctrl;
  localparam int CNT_W = 4;

  // {pc,fd,de,em,mw}_we , {fd,de,em,mw}_clr
  localparam logic [8:0] C_IDLE  = 9'b11111_0000;
  localparam logic [8:0] C_RST   = 9'b00000_0000;
  localparam logic [8:0] C_LU    = 9'b00111_0100;
  localparam logic [8:0] C_REDIR = 9'b11111_1100;
  localparam logic [8:0] C_MD    = 9'b00011_0010;
  localparam logic [8:0] C_MWAIT = 9'b00001_0001;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.MULDIV_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [8:0] ctl;
  assign ctl = {bus.pc_we, bus.fd_we, bus.de_we, bus.em_we, bus.mw_we,
                bus.fd_clr, bus.de_clr, bus.em_clr, bus.mw_clr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.rs1_d = 5'd0; bus.rs2_d = 5'd0; bus.rd_e = 5'd0;
    bus.use_rs1_d = 1'b0; bus.use_rs2_d = 1'b0;
    bus.mem_read_e = 1'b0; bus.muldiv_e = 1'b0; bus.redirect_e = 1'b0;
    bus.mem_req_m = 1'b0; bus.mem_ready_m = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    bus.mem_read_e = 1'b1; bus.rd_e = rd; bus.rs2_d = rd; bus.use_rs2_d = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic [8:0] md_ctl  [8];
  logic       md_busy [8];

  initial begin
    idle_in();
    reset = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_stall", 32'(bus.stall_count), 0);
    chk("rst_flush", 32'(bus.flush_count), 0);
    chk("rst_busy", 32'(bus.muldiv_busy), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

    // load-use: one stall cycle
    set_lu(5'd5); #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick(); idle_in(); #1;
    chk("lu_after", 32'(ctl), 32'(C_IDLE));
    chk("lu_stall", 32'(bus.stall_count), 1);
    // rd = x0 never hazards
    set_lu(5'd0); #1;
    chk("lu_x0_ctl", 32'(ctl), 32'(C_IDLE));
    tick(); idle_in(); #1;
    chk("lu_x0_stall", 32'(bus.stall_count), 1);
    // rs1 path
    bus.mem_read_e = 1'b1; bus.rd_e = 5'd9; bus.rs1_d = 5'd9; bus.use_rs1_d = 1'b1; #1;
    chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    bus.use_rs1_d = 1'b0; #1;
    chk("lu_nouse_ctl", 32'(ctl), 32'(C_IDLE));
    idle_in(); #1;

    // redirect
    bus.redirect_e = 1'b1; #1;
    chk("redir_ctl", 32'(ctl), 32'(C_REDIR));
    tick(); idle_in(); #1;
    chk("redir_flush", 32'(bus.flush_count), 1);
    bus.redirect_e = 1'b1; set_lu(5'd5); #1;
    chk("redir_lu_ctl", 32'(ctl), 32'(C_REDIR));
    tick(); idle_in(); #1;
    chk("redir_lu_flush", 32'(bus.flush_count), 2);
    chk("redir_lu_stall", 32'(bus.stall_count), 1);

    // back-to-back mul/div, muldiv_e held for 8 cycles
    do_reset();
    md_ctl  = '{C_MD, C_MD, C_MD, C_IDLE, C_MD, C_MD, C_MD, C_IDLE};
    md_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.muldiv_e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("md_ctl_c%0d", i + 1), 32'(ctl), 32'(md_ctl[i]));
      chk($sformatf("md_busy_c%0d", i + 1), 32'(bus.muldiv_busy), 32'(md_busy[i]));
      tick();
    end
    bus.muldiv_e = 1'b0; #1;
    chk("md_done_ctl", 32'(ctl), 32'(C_IDLE));
    chk("md_done_busy", 32'(bus.muldiv_busy), 0);
    chk("md_stall", 32'(bus.stall_count), 6);

    // memory wait frozen over the second mul/div cycle
    do_reset();
    bus.muldiv_e = 1'b1; #1;
    chk("mw_c1_ctl", 32'(ctl), 32'(C_MD));
    tick(); bus.muldiv_e = 1'b0;
    bus.mem_req_m = 1'b1; bus.mem_ready_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frz%0d_ctl", i), 32'(ctl), 32'(C_MWAIT));
      chk($sformatf("mw_frz%0d_busy", i), 32'(bus.muldiv_busy), 1);
      tick();
    end
    bus.mem_ready_m = 1'b1; #1;
    chk("mw_cnt1_ctl", 32'(ctl), 32'(C_MD));
    tick(); #1;
    chk("mw_cnt2_ctl", 32'(ctl), 32'(C_MD));
    tick(); #1;
    chk("mw_rel_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mw_rel_busy", 32'(bus.muldiv_busy), 1);
    tick(); idle_in(); #1;
    chk("mw_stall", 32'(bus.stall_count), 6);
    chk("mw_end_busy", 32'(bus.muldiv_busy), 0);

    // asynchronous abort mid mul/div
    bus.muldiv_e = 1'b1;
    tick(); bus.muldiv_e = 1'b0; #1;
    chk("ar_busy_pre", 32'(bus.muldiv_busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("ar_busy", 32'(bus.muldiv_busy), 0);
    chk("ar_ctl", 32'(ctl), 32'(C_RST));
    chk("ar_stall", 32'(bus.stall_count), 0);
    tick();
    reset = 1'b0; #1;
    chk("ar_idle_ctl", 32'(ctl), 32'(C_IDLE));

    // saturation at 2^CNT_W-1 under 20 stall cycles
    set_lu(5'd7);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_15", 32'(bus.stall_count), 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_20", 32'(bus.stall_count), 15);
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage RISC-V pipeline. It generates the write-enable (hold) and synchronous-clear (bubble) controls for the PC and for the FD, DE, EM and MW pipeline register banks. It resolves four conditions: load-use hazards, taken branches and jumps redirected in EX, multi-cycle mul/div occupancy of EX, and data-memory wait states. It also keeps saturating stall and flush performance counters.

## Interface

Parameters:
- MULDIV_LAT, default 4: cycles a mul/div op occupies EX. Legal range is 2 or more.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1_d, rs2_d  in  5 each  source registers of the instruction in ID
- use_rs1_d, use_rs2_d  in  1 each  the ID instruction reads rs1 / rs2
- rd_e  in  5  destination register of the instruction in EX
- mem_read_e  in  1  the EX instruction is a load
- muldiv_e  in  1  the EX instruction is a multi-cycle mul/div
- redirect_e  in  1  branch taken or jump resolved in EX
- mem_req_m  in  1  the MEM instruction accesses data memory
- mem_ready_m  in  1  data memory completes this cycle
- pc_we, fd_we, de_we, em_we, mw_we  out  1 each  stage register capture enables
- fd_clr, de_clr, em_clr, mw_clr  out  1 each  synchronous bubble-insert (clear) requests
- muldiv_busy  out  1  FSM is in state MULDIV
- stall_count  out  CNT_W  cycles with pc_we = 0 (saturating)
- flush_count  out  CNT_W  cycles in which a redirect was applied (saturating)

## Operation

Derived conditions:
- mem_wait = mem_req_m & !mem_ready_m.
- load_use = mem_read_e & rd_e != 0 & ((use_rs1_d & rs1_d == rd_e) | (use_rs2_d & rs2_d == rd_e)).

FSM states: RUN, MULDIV. A cycle counter cnt is ceil(log2(MULDIV_LAT)) bits wide.

Defaults:
- All *_we = 1.
- All *_clr = 0.

The first matching rule in the following priority order overrides the defaults:
1. **mem_wait** (memory wait)
   - pc_we, fd_we, de_we and em_we = 0.
   - mw_clr = 1, which sends a bubble into WB.
   - The FSM and cnt hold.
   - Any redirect, load-use or mul/div action is suppressed. Each re-evaluates when the freeze ends, because the instruction causing it is still in place.
2. **Mul/div stall**: state RUN with muldiv_e, or state MULDIV with cnt < MULDIV_LAT-1.
   - pc_we, fd_we and de_we = 0.
   - em_clr = 1.
   - In RUN the FSM moves to MULDIV with cnt = 1.
   - In MULDIV, cnt increments.
3. **Release**: state MULDIV with cnt == MULDIV_LAT-1.
   - Defaults apply, so EM captures the result.
   - The FSM returns to RUN and cnt resets to 0.
4. **redirect_e**
   - fd_clr = 1 and de_clr = 1.
   - The PC loads the target.
   - Redirect takes precedence over load_use.
5. **load_use**
   - pc_we = 0 and fd_we = 0.
   - de_clr = 1.
   - This lasts one cycle only, because the load leaves EX afterwards.

Every *_clr output is qualified with its matching *_we = 1. A clear therefore acts as "capture a bubble".

Counters:
- stall_count increments in each cycle with pc_we = 0.
- flush_count increments in each cycle where rule 4 is applied.
- Both saturate at 2^CNT_W - 1 and do not wrap.

## Timing

- All outputs are Mealy: combinational from the registered state, cnt and the current-cycle inputs. Pipeline registers act on them at the next clk rising edge.
- While reset is high:
  - All *_we and *_clr = 0.
  - state = RUN, cnt = 0.
  - stall_count and flush_count = 0.
  - muldiv_busy = 0.
- After reset, with idle inputs: all *_we = 1 and all *_clr = 0.
- Reset asserted mid-MULDIV aborts the op immediately (asynchronously).
- A mul/div op holds EX for exactly MULDIV_LAT non-frozen cycles. MULDIV_LAT-1 of them are stall cycles.
- muldiv_e asserted on the release cycle belongs to the next instruction and is only evaluated in RUN on the following cycle. Back-to-back mul/div ops therefore each take the full latency.
- Load-use costs 1 stall cycle. A redirect costs 2 bubbles.

## Structure

- Package pipe_ctrl_pkg:
  - state enum {RUN, MULDIV}
  - X0 register index constant (0)
- Sub-module sat_counter, parameterized by width with an inc input. It is instantiated twice, once for each performance counter.
- Hazard detection is kept inline.

## Test plan

- Reset with all inputs idle → all *_we = 1, all *_clr = 0, both counters = 0.
- Load-use: mem_read_e = 1, rd_e = 5, rs2_d = 5, use_rs2_d = 1 → exactly one cycle with pc_we = fd_we = 0 and de_clr = 1; stall_count = 1. Repeat with rd_e = 0 → no stall.
- redirect_e pulsed for 1 cycle → fd_clr = de_clr = 1 that cycle; flush_count = 1. With load_use asserted in the same cycle → redirect still applied and no stall.
- MULDIV_LAT = 4, muldiv_e held → 3 stall cycles with em_clr = 1, muldiv_busy high for cycles 2–4, then release. Back-to-back ops → 6 total stall cycles.
- mem_wait held for 3 cycles during the second MULDIV cycle → all upstream we = 0 and mw_clr = 1 for 3 cycles, cnt held, total stall cycles = 3 + 3.
- Reset asserted in MULDIV → state returns to RUN and all outputs reach their reset values without waiting for a clock edge. CNT_W = 4 with 20 stalls → stall_count saturates at 15.
